fir_decim_requant: RTL and testbench
====================================

Name: fir_decim_requant

Overview:
- Downstream stage of the FIR filter. Consumes the FIR's 16-bit signed output stream.
- Decimates the stream by DECIM and requantizes each kept sample to OUT_W bits: arithmetic right shift with round-half-up, then saturation.
- Buffers the results in a small show-ahead FIFO and presents them on a valid/ready interface to the next consumer.

Parameters:
- IN_W, 16, width of the signed input sample (FIR y_out width).
- OUT_W, 8, width of the signed output sample.
- SHIFT, 2, right-shift amount applied before saturation; must be ≥1.
- DECIM, 2, decimation factor; keep 1 of every DECIM accepted samples; must be ≥1.
- DEPTH, 4, FIFO depth; must be a power of 2, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- in_valid  in  1  in_data is valid this cycle. There is no backpressure upstream.
- in_data  in  IN_W  signed FIR output sample.
- out_valid  out  1  FIFO non-empty; out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  OUT_W  signed requantized sample at the FIFO head.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
- sat_flag  out  1  sticky: a kept sample saturated.
- clear_sat  in  1  synchronous clear of sat_flag.
- drop_pulse  out  1  one-cycle pulse: a kept sample was discarded because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): the following clear immediately, regardless of clk.
  - Decimation counter cleared.
  - Stage-1 valid cleared.
  - FIFO pointers cleared.
  - out_valid=0, out_data=0, fifo_count=0, sat_flag=0, drop_pulse=0.
- Reset mid-operation: all FIFO contents and any in-flight stage-1 sample are discarded. No output appears until new input arrives after reset release.
- Decimation:
  - phase counter runs 0..DECIM-1 and advances only on in_valid=1, wrapping to 0 after DECIM-1.
  - A sample is kept when in_valid=1 and phase==0.
  - With DECIM=1, every valid sample is kept.
- Requantization (stage 1, registered):
  - Compute t = (sign-extended in_data to IN_W+1 bits) + 2^(SHIFT-1).
  - r = t >>> SHIFT (arithmetic).
  - If r > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1 and flag saturation.
  - If r < -2^(OUT_W-1), output -2^(OUT_W-1) and flag saturation.
  - Otherwise output r[OUT_W-1:0].
  - The stage-1 register and its valid bit update at the same edge that accepts the kept sample.
- FIFO write: the edge after stage-1 capture writes the stage-1 result.
  - push = stage-1 valid.
  - Push succeeds if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle.
  - Otherwise the sample is discarded: drop_pulse=1 for that cycle, count unchanged.
- FIFO read: pop = out_valid && out_ready.
  - out_data always shows the head entry combinationally from storage (show-ahead).
  - out_data holds its last value when empty; after reset it is 0.
- Simultaneous push and pop: count unchanged, both pointers advance; legal at any occupancy including full.
- Pop when empty: ignored; out_ready while out_valid=0 has no effect.
- Latency: kept sample at edge E → stage-1 at E → FIFO at E+1 → out_valid high after E+1, when the FIFO was empty and no drop occurred.
- Pointers: wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit so that full and empty are distinguishable.
- sat_flag:
  - Set on the edge at which a saturated sample is captured into stage 1, even if it is later dropped.
  - clear_sat=1 clears it on the next edge.
  - If a set and a clear occur on the same edge, set wins.
- drop_pulse is registered; it asserts for exactly one cycle per dropped sample.
- Non-kept samples have no effect on stage 1, the FIFO or the flags.

Test Plan (default parameters):
1. Basic decimate/round: after reset release, in_valid=1 with in_data=100,200,300,400 on consecutive cycles and out_ready=1.
   - out_data sequence is 25, then 75; 200 and 400 are not output.
   - First out_valid appears 2 edges after 100 is presented.
2. Rounding and sign: kept inputs 6, -6, 5, -5.
   - Outputs 2, -1, 1, -1 (i.e. 8>>>2, -4>>>2, 7>>>2, -3>>>2).
   - sat_flag stays 0.
3. Saturation: kept inputs 1000 and -1000.
   - Outputs 127 and -128; sat_flag=1 and stays set.
   - Pulse clear_sat=1 → sat_flag=0 next edge.
   - A further kept input 600 together with clear_sat=1 → sat_flag remains 1.
4. Full/drop: out_ready=0, 5 kept samples 4,8,12,16,20.
   - fifo_count climbs to 4.
   - The 5th kept sample (20, giving 5) raises drop_pulse for 1 cycle; count stays 4.
   - Raising out_ready drains 1,2,3,4 in order.
5. Full with concurrent pop: FIFO full, out_ready=1 and a new kept sample arrive on the same cycle.
   - No drop; fifo_count stays 4.
   - Head advances and the new value is enqueued at the tail.
6. Reset mid-operation: FIFO holding 3 entries plus a stage-1 sample in flight; pulse reset=0 between clock edges.
   - out_valid=0, fifo_count=0, sat_flag=0 immediately.
   - After release, the first kept input is 40 and the first output is 10 (phase restarts at 0).

Source files
------------

// File: rtl/fir_decim_requant_if.sv
// Valid/ready bundle between the FIR output, the decimating requantizer and its consumer.
interface fir_decim_requant_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/fir_decim_requant.sv
// Keeps 1 of DECIM FIR samples, rounds/shifts/saturates it to OUT_W bits and
// queues the result in a show-ahead FIFO for a valid/ready consumer.
module fir_decim_requant #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 2,
    parameter int DECIM = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    fir_decim_requant_if.slave       bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     sat_flag,
    input  logic                     clear_sat,
    output logic                     drop_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2 ** (OUT_W - 1)));

    logic [PW-1:0]            phase;
    logic                     keep;
    logic signed [IN_W:0]     t_sum;
    logic signed [IN_W:0]     r_shift;
    logic signed [OUT_W-1:0]  q_data;
    logic                     q_sat;
    logic                     s1_valid;
    logic signed [OUT_W-1:0]  s1_data;
    logic signed [OUT_W-1:0]  mem [DEPTH];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic signed [OUT_W-1:0]  last_data;
    logic                     full;
    logic                     pop;
    logic                     push_ok;

    assign keep = bus.in_valid && (phase == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (bus.in_valid) begin
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
        end
    end

    // Sign-extend one bit so adding the rounding constant cannot overflow.
    always_comb begin
        t_sum   = {bus.in_data[IN_W-1], bus.in_data} + RND;
        r_shift = t_sum >>> SHIFT;
        q_sat   = 1'b0;
        q_data  = r_shift[OUT_W-1:0];
        if (r_shift > MAXV) begin
            q_data = MAXV[OUT_W-1:0];
            q_sat  = 1'b1;
        end else if (r_shift < MINV) begin
            q_data = MINV[OUT_W-1:0];
            q_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_data <= q_data;
            end
        end
    end

    // A saturation captured this edge outranks a simultaneous clear request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_flag <= 1'b0;
        end else if (keep && q_sat) begin
            sat_flag <= 1'b1;
        end else if (clear_sat) begin
            sat_flag <= 1'b0;
        end
    end

    assign fifo_count    = wr_ptr - rd_ptr;
    assign full          = (fifo_count == (AW+1)'(DEPTH));
    assign bus.out_valid = (fifo_count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign push_ok       = s1_valid && (!full || pop);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr[AW-1:0]] : last_data;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= s1_data;
        end
    end

    // last_data keeps the most recently consumed entry visible while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_data  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= s1_valid && !push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + (AW+1)'(1);
                last_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_fir_decim_requant.sv
// Bench for fir_decim_requant: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_fir_decim_requant;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SHIFT = 2;
    localparam int DECIM = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic clear_sat;
    logic [$clog2(DEPTH):0] fifo_count;
    logic sat_flag;
    logic drop_pulse;

    fir_decim_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    fir_decim_requant #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DECIM), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .fifo_count(fifo_count),
        .sat_flag(sat_flag),
        .clear_sat(clear_sat),
        .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int ph_m;
    bit s1v_m;
    int s1d_m;
    bit sat_m;
    bit drop_m;
    int last_m;
    int q_m[$];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Round-half-up divide by 2^SHIFT using floor division, then clamp.
    function automatic int requant(input int x, output bit sat);
        int d;
        int t;
        int r;
        d = 1 << SHIFT;
        t = x + d / 2;
        r = (t >= 0) ? t / d : -((-t + d - 1) / d);
        sat = 1'b0;
        if (r > 2 ** (OUT_W - 1) - 1) begin
            r = 2 ** (OUT_W - 1) - 1;
            sat = 1'b1;
        end else if (r < -(2 ** (OUT_W - 1))) begin
            r = -(2 ** (OUT_W - 1));
            sat = 1'b1;
        end
        return r;
    endfunction

    task automatic modelReset();
        ph_m = 0; s1v_m = 0; s1d_m = 0; sat_m = 0; drop_m = 0; last_m = 0;
        q_m.delete();
    endtask

    task automatic modelEdge(input bit v, input int d, input bit rdy, input bit clr);
        bit pop;
        bit keep;
        bit sat;
        int val;
        pop  = (q_m.size() > 0) && rdy;
        keep = v && (ph_m == 0);
        drop_m = 1'b0;
        if (pop) begin
            last_m = q_m[0];
            void'(q_m.pop_front());
        end
        if (s1v_m) begin
            if (q_m.size() < DEPTH) q_m.push_back(s1d_m);
            else drop_m = 1'b1;
        end
        if (keep) begin
            val = requant(d, sat);
            s1d_m = val;
            if (sat) sat_m = 1'b1;
            else if (clr) sat_m = 1'b0;
        end else if (clr) begin
            sat_m = 1'b0;
        end
        s1v_m = keep;
        if (v) ph_m = (ph_m + 1) % DECIM;
    endtask

    task automatic checkAll();
        checkOutput("out_valid", int'(bus.out_valid), int'(q_m.size() > 0));
        checkOutput("fifo_count", int'(fifo_count), q_m.size());
        checkOutput("out_data", int'($signed(bus.out_data)), (q_m.size() > 0) ? q_m[0] : last_m);
        checkOutput("sat_flag", int'(sat_flag), int'(sat_m));
        checkOutput("drop_pulse", int'(drop_pulse), int'(drop_m));
    endtask

    task automatic applyStimulus(input bit v, input int d, input bit rdy, input bit clr);
        bus.in_valid  = v;
        bus.in_data   = d[IN_W-1:0];
        bus.out_ready = rdy;
        clear_sat     = clr;
        @(posedge clk);
        modelEdge(v, d, rdy, clr);
        #1;
        checkAll();
    endtask

    // One kept sample followed by DECIM-1 discarded fillers, leaving phase at 0.
    task automatic sendKept(input int d, input bit rdy, input bit clr);
        applyStimulus(1'b1, d, rdy, clr);
        for (int i = 1; i < DECIM; i++) applyStimulus(1'b1, 12345, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, rdy, 1'b0);
    endtask

    task automatic midReset();
        #2 reset = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_fifo_count", int'(fifo_count), 0);
        checkOutput("rst_sat_flag", int'(sat_flag), 0);
        checkOutput("rst_out_data", int'($signed(bus.out_data)), 0);
        #2 reset = 1'b1;
    endtask

    initial begin
        int d;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; clear_sat = 1'b0;
        reset = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_fifo_count", int'(fifo_count), 0);
        checkOutput("reset_out_data", int'($signed(bus.out_data)), 0);
        checkOutput("reset_drop", int'(drop_pulse), 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] basic decimate/round");
        applyStimulus(1'b1, 100, 1'b1, 1'b0);
        applyStimulus(1'b1, 200, 1'b1, 1'b0);
        applyStimulus(1'b1, 300, 1'b1, 1'b0);
        applyStimulus(1'b1, 400, 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("[TB] rounding and sign");
        sendKept(6, 1'b1, 1'b0);
        sendKept(-6, 1'b1, 1'b0);
        sendKept(5, 1'b1, 1'b0);
        sendKept(-5, 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("[TB] saturation and sticky flag");
        sendKept(1000, 1'b1, 1'b0);
        sendKept(-1000, 1'b1, 1'b0);
        idle(2, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
        idle(1, 1'b1);
        sendKept(600, 1'b1, 1'b1);
        idle(3, 1'b1);

        $display("[TB] full and drop");
        sendKept(4, 1'b0, 1'b0);
        sendKept(8, 1'b0, 1'b0);
        sendKept(12, 1'b0, 1'b0);
        sendKept(16, 1'b0, 1'b0);
        sendKept(20, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        $display("[TB] full with concurrent pop");
        for (int i = 0; i < DEPTH; i++) sendKept(40 + 4 * i, 1'b0, 1'b0);
        idle(2, 1'b0);
        applyStimulus(1'b1, 80, 1'b0, 1'b0);
        applyStimulus(1'b1, 12345, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) sendKept(-20 - 4 * i, 1'b0, 1'b0);
        idle(1, 1'b0);
        applyStimulus(1'b1, 44, 1'b0, 1'b0);
        midReset();
        idle(2, 1'b1);
        sendKept(40, 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 1200)) - 600;
            else d = int'($urandom_range(0, 65535)) - 32768;
            applyStimulus(1'($urandom_range(0, 3) != 0), d,
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        idle(8, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
